// File: rtl/ahb_mailbox.sv
// ahb_mailbox: AHB-Lite bench mailbox; buffers console chars, flags pass/fail, exposes a status word.
// Optional watchdog timeout (status bit 2) is built when MBOX_WATCHDOG_EN is defined.
module ahb_mailbox #(
    parameter logic [31:0] MBOX_ADDR  = 32'hD0580000,
    parameter logic [31:0] STAT_ADDR  = 32'hD0580008,
    parameter int          FIFO_DEPTH = 8
`ifdef MBOX_WATCHDOG_EN
    ,
    parameter logic [31:0] MAX_CYCLES = 32'h800
`endif
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [63:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [63:0] HRDATA,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        finished,
    output logic        failed
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic          dphase, a_write;
    logic [31:0]   a_addr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    wbyte;
    logic          accept, wr_mbox, is_char, stall, push, pop, timeout, unused_ok;

    assign accept     = HSEL & HREADY & HTRANS[1];
    assign wbyte      = HWDATA[{a_addr[2:0], 3'b000} +: 8];
    assign wr_mbox    = dphase & a_write & (a_addr == MBOX_ADDR);
    assign is_char    = (wbyte > 8'h06) & (wbyte < 8'h7F);
    // A character write into a full FIFO holds the data phase until a slot frees up.
    assign stall      = wr_mbox & is_char & (count == CW'(FIFO_DEPTH));
    assign push       = wr_mbox & is_char & ~stall;
    assign pop        = char_valid & char_ready;
    assign HREADYOUT  = ~stall;
    assign HRESP      = 1'b0;
    assign HRDATA     = (dphase & ~a_write & (a_addr == STAT_ADDR)) ?
                        {48'h0, 8'(count), 5'b0, timeout, failed, finished} : 64'h0;
    assign char_valid = count != '0;
    assign char_data  = char_valid ? mem[rd_ptr] : 8'h0;
    assign unused_ok  = ^{HSIZE, HTRANS[0]};

    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= wbyte;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase   <= 1'b0;
            a_write  <= 1'b0;
            a_addr   <= 32'h0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            finished <= 1'b0;
            failed   <= 1'b0;
        end else begin
            if (HREADYOUT) begin
                dphase <= accept;
                if (accept) begin
                    a_addr  <= HADDR;
                    a_write <= HWRITE;
                end
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (wr_mbox && wbyte == 8'hFF) finished <= 1'b1;
            if (wr_mbox && wbyte == 8'h01) failed <= 1'b1;
        end
    end

`ifdef MBOX_WATCHDOG_EN
    logic [31:0] cycles;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cycles  <= 32'h0;
            timeout <= 1'b0;
        end else if (!finished && !failed && !timeout) begin
            if (cycles == MAX_CYCLES) timeout <= 1'b1;
            else cycles <= cycles + 32'h1;
        end
    end
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_mailbox.sv
// tb_ahb_mailbox: directed checks of the AHB mailbox (chars, stall, pass/fail, status, reset).
module tb_ahb_mailbox;
    localparam logic [31:0] MBOX = 32'hD0580000;
    localparam logic [31:0] STAT = 32'hD0580008;
`ifdef MBOX_WATCHDOG_EN
    localparam logic [63:0] WD = 64'h4;
`else
    localparam logic [63:0] WD = 64'h0;
`endif

    logic        HCLK = 0, HRESETn = 0, HSEL = 0, HWRITE = 0, char_ready = 0;
    logic [31:0] HADDR = 0;
    logic [1:0]  HTRANS = 0;
    logic [2:0]  HSIZE = 0;
    logic [63:0] HWDATA = 0, HRDATA, rd;
    logic        HREADY, HREADYOUT, HRESP, char_valid, finished, failed;
    logic [7:0]  char_data;
    int          checks = 0, failures = 0;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_mailbox #(
        .FIFO_DEPTH(8)
`ifdef MBOX_WATCHDOG_EN
        , .MAX_CYCLES(32'd16)
`endif
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .char_valid(char_valid),
        .char_data(char_data), .char_ready(char_ready), .finished(finished), .failed(failed)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w);
        HSEL = 1; HTRANS = 2'b10; HADDR = a; HWRITE = w;
    endtask

    task automatic idle();
        HSEL = 0; HTRANS = 2'b00;
    endtask

    task automatic wdata(input logic [31:0] a, input logic [7:0] d);
        HWDATA = {56'h0, d} << {a[2:0], 3'b000};
    endtask

    // Zero-wait write expected; any stall is bounded and reported.
    task automatic write(input logic [31:0] a, input logic [7:0] d);
        int n = 0;
        addr_phase(a, 1);
        @(posedge HCLK); #1;
        idle();
        wdata(a, d);
        @(negedge HCLK);
        chk("write_no_wait", {63'h0, HREADYOUT}, 64'h1);
        while (!HREADYOUT && n < 20) begin
            @(negedge HCLK);
            n++;
        end
        @(posedge HCLK); #1;
    endtask

    task automatic read(input logic [31:0] a, output logic [63:0] d);
        addr_phase(a, 0);
        @(posedge HCLK); #1;
        idle();
        @(negedge HCLK);
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation hung");
    end

    initial begin
        @(negedge HCLK);
        chk("rst_hreadyout", {63'h0, HREADYOUT}, 64'h1);
        chk("rst_hresp", {63'h0, HRESP}, 64'h0);
        chk("rst_hrdata", HRDATA, 64'h0);
        chk("rst_flags", {60'h0, char_valid, finished, failed, |char_data}, 64'h0);
        @(posedge HCLK); #1;
        HRESETn = 1;

        // Watchdog: idle long enough to pass MAX_CYCLES=16
        repeat (30) @(posedge HCLK);
        #1;
        read(STAT, rd);
        chk("wd_status", rd, WD);
        @(negedge HCLK);
        chk("hrdata_idle", HRDATA, 64'h0);
        @(posedge HCLK); #1;

        // Single char with sink ready: visible for one cycle
        char_ready = 1;
        write(MBOX, 8'h48);
        @(negedge HCLK);
        chk("h_valid", {63'h0, char_valid}, 64'h1);
        chk("h_data", {56'h0, char_data}, 64'h48);
        @(negedge HCLK);
        chk("h_drained", {63'h0, char_valid}, 64'h0);
        @(posedge HCLK); #1;
        char_ready = 0;

        // Fill FIFO, ninth char stalls
        for (int i = 0; i < 8; i++) write(MBOX, 8'h41 + 8'(i));
        addr_phase(MBOX, 1);
        @(posedge HCLK); #1;
        idle();
        wdata(MBOX, 8'h49);
        @(negedge HCLK);
        chk("stall_1", {63'h0, HREADYOUT}, 64'h0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("stall_2", {63'h0, HREADYOUT}, 64'h0);
        @(posedge HCLK); #1;
        char_ready = 1;
        @(negedge HCLK);
        chk("stall_pop_cycle", {63'h0, HREADYOUT}, 64'h0);
        chk("stall_head", {56'h0, char_data}, 64'h41);
        @(posedge HCLK); #1;
        char_ready = 0;
        @(negedge HCLK);
        chk("stall_release", {63'h0, HREADYOUT}, 64'h1);
        chk("head_after_pop", {56'h0, char_data}, 64'h42);
        @(posedge HCLK); #1;
        read(STAT, rd);
        chk("full_count", rd, 64'h800 | WD);
        char_ready = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge HCLK);
            chk("drain_data", {55'h0, char_valid, char_data}, {55'h0, 1'b1, 8'h42 + 8'(i)});
            @(posedge HCLK); #1;
        end
        char_ready = 0;
        @(negedge HCLK);
        chk("drain_empty", {63'h0, char_valid}, 64'h0);
        @(posedge HCLK); #1;

        // Pass code
        write(MBOX, 8'hFF);
        @(negedge HCLK);
        chk("finished_set", {62'h0, finished, failed}, 64'h2);
        @(posedge HCLK); #1;
        read(STAT, rd);
        chk("status_finished", rd, 64'h1 | WD);

        // Fail code and ignored values
        write(MBOX, 8'h01);
        write(MBOX, 8'h05);
        write(MBOX, 8'h7F);
        @(negedge HCLK);
        chk("failed_set", {61'h0, char_valid, finished, failed}, 64'h3);
        @(posedge HCLK); #1;

        // Character range boundaries, other address ignored
        write(MBOX, 8'h07);
        write(MBOX, 8'h06);
        write(MBOX, 8'h7E);
        write(MBOX + 32'h4, 8'h41);
        read(MBOX, rd);
        chk("mbox_read_zero", rd, 64'h0);
        read(STAT, rd);
        chk("boundary_count", rd, 64'h203 | WD);
        @(negedge HCLK);
        chk("boundary_head", {56'h0, char_data}, 64'h07);
        @(posedge HCLK); #1;

        // Back-to-back pipelined writes
        addr_phase(MBOX, 1);
        @(posedge HCLK); #1;
        wdata(MBOX, 8'h50);
        addr_phase(MBOX, 1);
        @(posedge HCLK); #1;
        idle();
        wdata(MBOX, 8'h51);
        @(posedge HCLK); #1;
        read(STAT, rd);
        chk("pipelined_count", rd, 64'h403 | WD);

        // Asynchronous reset mid-stream
        #2 HRESETn = 0;
        #1;
        chk("async_rst", {60'h0, HREADYOUT, char_valid, finished, failed}, 64'h8);
        @(posedge HCLK); #1;
        HRESETn = 1;
        read(STAT, rd);
        chk("post_rst_status", rd, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
